// File: rtl/reg_file_wb_sink.sv
// Architectural register file fed by the writeback stage; two registered read
// ports with same-cycle write bypass, plus a saturating committed-write counter.

module reg_file_wb_sink_rdport #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              byp
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              byp_q, byp_d;

  // flush outranks the advance strobe
  always_comb begin
    data_d = data_q;
    byp_d  = byp_q;
    if (flush) begin
      data_d = '0;
      byp_d  = 1'b0;
    end else if (rd_en) begin
      data_d = byp_hit ? byp_data : rf_data;
      byp_d  = byp_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      byp_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      byp_q  <= byp_d;
    end
  end

  assign rd_data = data_q;
  assign byp     = byp_q;
endmodule

module reg_file_wb_sink #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              byp_a,
  output logic              byp_b,
  output logic [CNT_W-1:0]  wr_count
);
  localparam int NREG  = 2**ADDR_W;
  localparam int NPORT = 2;

  logic [NREG-1:0][DATA_W-1:0]  regs_q;
  logic [NREG-1:0]              we_vec;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;
  logic [NPORT-1:0]             byp;

  // wb_we gates the decode so an unknown wb_waddr cannot reach any register
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < NREG; i++)
      we_vec[i] = wb_we && (wb_waddr == ADDR_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (we_vec[i]) regs_q[i] <= wb_wdata;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb_we && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rd_addr = {rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    logic hit;
    assign hit = wb_we && (wb_waddr == rd_addr[p]);
    reg_file_wb_sink_rdport #(.DATA_W(DATA_W)) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .flush    (flush),
      .byp_hit  (hit),
      .byp_data (wb_wdata),
      .rf_data  (regs_q[rd_addr[p]]),
      .rd_data  (rd_data[p]),
      .byp      (byp[p])
    );
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign byp_a     = byp[0];
  assign byp_b     = byp[1];
  assign wr_count  = cnt_q;
endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Directed bench for reg_file_wb_sink: reset, write/read, bypass, hold/flush,
// write-enable gating and counter saturation with async reset.

module tb_reg_file_wb_sink;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_we;
  logic [2:0] wb_waddr;
  logic [7:0] wb_wdata;
  logic       rd_en;
  logic       flush;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       byp_a;
  logic       byp_b;
  logic [7:0] wr_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  reg_file_wb_sink dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .rd_en     (rd_en),
    .flush     (flush),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .byp_a     (byp_a),
    .byp_b     (byp_b),
    .wr_count  (wr_count)
  );

  // one clock: drive at negedge, return 1 time unit after the posedge
  task automatic cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic en, input logic fl,
                       input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    rd_en = en; flush = fl; rd_addr_a = a; rd_addr_b = b;
    @(posedge clk);
    #1;
    if (we && rst_n && exp_cnt < 255) exp_cnt++;
    wb_we = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'(i), 3'd0);
      checks++;
      if (rd_data_a !== 8'h00 || byp_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_read r%0d got %h/%b exp 00/0", i, rd_data_a, byp_a);
      end
    end
    checks++;
    if (wr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", wr_count);
    end
  endtask

  task automatic test_write_read;
    cycle(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 3'd0, 3'd0);
    cycle(1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd3, 3'd5);
    checks++;
    if (rd_data_a !== 8'hA5 || rd_data_b !== 8'h3C || byp_a !== 1'b0 || byp_b !== 1'b0) begin
      errors++;
      $display("FAIL write_read got %h %h %b%b exp a5 3c 00", rd_data_a, rd_data_b, byp_a, byp_b);
    end
    checks++;
    if (wr_count !== 8'd2) begin
      errors++;
      $display("FAIL write_read_count got %0d exp 2", wr_count);
    end
  endtask

  task automatic test_bypass;
    cycle(1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 3'd0, 3'd0);
    cycle(1'b1, 3'd2, 8'h7E, 1'b1, 1'b0, 3'd2, 3'd2);
    checks++;
    if (rd_data_a !== 8'h7E || rd_data_b !== 8'h7E || byp_a !== 1'b1 || byp_b !== 1'b1) begin
      errors++;
      $display("FAIL bypass_both got %h %h %b%b exp 7e 7e 11", rd_data_a, rd_data_b, byp_a, byp_b);
    end
    cycle(1'b1, 3'd0, 8'h5A, 1'b1, 1'b0, 3'd0, 3'd3);
    checks++;
    if (rd_data_a !== 8'h5A || rd_data_b !== 8'hA5 || byp_a !== 1'b1 || byp_b !== 1'b0) begin
      errors++;
      $display("FAIL bypass_split got %h %h %b%b exp 5a a5 10", rd_data_a, rd_data_b, byp_a, byp_b);
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd2, 3'd2);
    checks++;
    if (rd_data_a !== 8'h7E || rd_data_b !== 8'h7E || byp_a !== 1'b0 || byp_b !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after got %h %h %b%b exp 7e 7e 00", rd_data_a, rd_data_b, byp_a, byp_b);
    end
  endtask

  task automatic test_hold_flush;
    cycle(1'b1, 3'd6, 8'h66, 1'b0, 1'b0, 3'd5, 3'd1);
    checks++;
    if (rd_data_a !== 8'h7E || rd_data_b !== 8'h7E || byp_a !== 1'b0) begin
      errors++;
      $display("FAIL hold got %h %h %b exp 7e 7e 0", rd_data_a, rd_data_b, byp_a);
    end
    cycle(1'b1, 3'd4, 8'h99, 1'b1, 1'b1, 3'd4, 3'd4);
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || byp_a !== 1'b0 || byp_b !== 1'b0) begin
      errors++;
      $display("FAIL flush got %h %h %b%b exp 00 00 00", rd_data_a, rd_data_b, byp_a, byp_b);
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd4, 3'd6);
    checks++;
    if (rd_data_a !== 8'h99 || rd_data_b !== 8'h66) begin
      errors++;
      $display("FAIL flush_write_kept got %h %h exp 99 66", rd_data_a, rd_data_b);
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd4, 3'd6);
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL flush_no_en got %h %h exp 00 00", rd_data_a, rd_data_b);
    end
    checks++;
    if (wr_count !== 8'(exp_cnt) || exp_cnt != 7) begin
      errors++;
      $display("FAIL hold_flush_count got %0d exp 7", wr_count);
    end
  endtask

  task automatic test_we_low;
    cycle(1'b1, 3'd1, 8'h55, 1'b0, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd1, 8'hFF, 1'b1, 1'b0, 3'd1, 3'd1);
    checks++;
    if (rd_data_a !== 8'h55 || byp_a !== 1'b0 || byp_b !== 1'b0) begin
      errors++;
      $display("FAIL we_low_nobyp got %h %b%b exp 55 00", rd_data_a, byp_a, byp_b);
    end
    cycle(1'b0, 3'bxxx, 8'hEE, 1'b0, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 3'd3);
    checks++;
    if (rd_data_a !== 8'h55 || rd_data_b !== 8'hA5) begin
      errors++;
      $display("FAIL we_low_hold got %h %h exp 55 a5", rd_data_a, rd_data_b);
    end
    checks++;
    if (wr_count !== 8'd8) begin
      errors++;
      $display("FAIL we_low_count got %0d exp 8", wr_count);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, 3'd7, 8'(i), 1'b0, 1'b0, 3'd0, 3'd0);
      checks++;
      if (wr_count !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_step %0d got %0d exp %0d", i, wr_count, exp_cnt);
      end
    end
    checks++;
    if (wr_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_final got %0d exp 255", wr_count);
    end
    // make outputs nonzero, then reset mid-cycle together with a pending write
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd3, 3'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0; wb_we = 1'b1; wb_waddr = 3'd6; wb_wdata = 8'h42;
    #1;
    checks++;
    if (wr_count !== 8'd0 || rd_data_a !== 8'h00 || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %0d %h %h exp 0 00 00", wr_count, rd_data_a, rd_data_b);
    end
    @(negedge clk);
    rst_n = 1'b1; wb_we = 1'b0;
    exp_cnt = 0;
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd6, 3'd3);
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_discard got %h %h %0d exp 00 00 0", rd_data_a, rd_data_b, wr_count);
    end
    cycle(1'b1, 3'd6, 8'hC3, 1'b1, 1'b0, 3'd6, 3'd6);
    checks++;
    if (rd_data_a !== 8'hC3 || byp_a !== 1'b1 || wr_count !== 8'd1) begin
      errors++;
      $display("FAIL post_reset got %h %b %0d exp c3 1 1", rd_data_a, byp_a, wr_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    rd_en = 1'b0; flush = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    #3;
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || byp_a !== 1'b0 || byp_b !== 1'b0 || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async_out got %h %h %b%b %0d exp all 0", rd_data_a, rd_data_b, byp_a, byp_b, wr_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_write_read;
    test_bypass;
    test_hold_flush;
    test_we_low;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_wb_sink.md
Name: reg_file_wb_sink

Overview:
- Architectural register file at the receiving end of the writeback path.
- Accepts the WB-stage write triple (enable, register number, data) and serves two read ports to the decode stage.
- Read results are registered into the ID/EX boundary.
- A same-cycle write to a register being read is bypassed into the read result.
- Provides a committed-write counter for debug and verification.

Parameters:
- DATA_W, 8, register and datapath width in bits.
- ADDR_W, 3, register-number width; register count is 2**ADDR_W.
- RESET_VAL, 0, value loaded into every register on reset.
- CNT_W, 8, width of the committed-write counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_we  in  1  write enable from the writeback stage.
- wb_waddr  in  ADDR_W  destination register number from the writeback stage.
- wb_wdata  in  DATA_W  writeback data (ALU result or source-register data, already muxed).
- rd_en  in  1  decode-stage advance strobe; captures new read results when high.
- flush  in  1  pipeline flush; clears the registered read outputs.
- rd_addr_a  in  ADDR_W  read port A register number.
- rd_addr_b  in  ADDR_W  read port B register number.
- rd_data_a  out  DATA_W  registered port A result.
- rd_data_b  out  DATA_W  registered port B result.
- byp_a  out  1  registered flag: rd_data_a was taken from wb_wdata.
- byp_b  out  1  registered flag: rd_data_b was taken from wb_wdata.
- wr_count  out  CNT_W  number of committed writes, saturating.

Behaviour:
- Reset: asynchronous on rst_n low, independent of clk.
  - All registers become RESET_VAL.
  - rd_data_a/b, byp_a/b and wr_count become 0.
  - State holds while rst_n is low. The first edge after deassertion behaves normally.
  - A reset asserted mid-write discards that write.
- Write:
  - On a rising edge with wb_we=1, reg[wb_waddr] <= wb_wdata.
  - Every register number is writable; there is no hardwired zero register.
  - wb_we=0 leaves all registers unchanged, whatever wb_waddr and wb_wdata are.
- Read:
  - Latency is 1 cycle: addresses presented in cycle N appear on rd_data_* after edge N.
  - On an edge with rd_en=1 and flush=0, for each port p:
    - If wb_we=1 and wb_waddr==rd_addr_p: rd_data_p <= wb_wdata and byp_p <= 1.
    - Otherwise: rd_data_p <= reg[rd_addr_p] (the pre-edge value) and byp_p <= 0.
  - Both ports may name the same register, and both may bypass in the same cycle.
  - rd_en=0 and flush=0: rd_data_* and byp_* hold their values. The write still occurs.
  - flush=1: rd_data_* and byp_* go to 0 on the edge, regardless of rd_en. The write still occurs.
- Counter:
  - wr_count increments by 1 on each edge with wb_we=1.
  - It saturates at 2**CNT_W-1 and does not wrap.
- Widths: no arithmetic on data; widths are exact, with no extension or truncation.
- Undefined inputs (X) on wb_waddr while wb_we=0 must not corrupt state.

Test Plan:
- Reset then read all: assert rst_n=0 mid-cycle, release, then read r0..r7 via port A -> all 0x00, byp_a=0, wr_count=0; outputs are 0 immediately on reset assertion, without waiting for a clock.
- Write then read: write r3=0xA5 (wb_we=1) and r5=0x3C on consecutive cycles, then rd_en=1 with a=3, b=5 -> one cycle later rd_data_a=0xA5, rd_data_b=0x3C, byp=0, wr_count=2.
- Same-cycle bypass: r2 holds 0x11; in one cycle wb_we=1, waddr=2, wdata=0x7E, rd_en=1, a=2, b=2 -> rd_data_a=rd_data_b=0x7E, byp_a=byp_b=1; next read of r2 without a write -> 0x7E, byp=0.
- Hold and flush: with rd_data_a=0x7E, set rd_en=0 and change rd_addr_a -> output stays 0x7E. Then flush=1 together with rd_en=1 and a write to r4=0x99 -> rd_data_*=0, byp=0; a later read of r4 returns 0x99.
- Write enable low: wb_we=0 with waddr=1, wdata=0xFF -> a later read of r1 returns the prior value; wr_count unchanged.
- Counter saturation: 260 consecutive writes -> wr_count reaches 255 and stays 255; reset mid-sequence returns it to 0.
